// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-fed ALU sequencer.
package uart_alu_pkg;

    typedef enum logic [7:0] {
        OP_ADD    = 8'h00,
        OP_SUB    = 8'h01,
        OP_AND    = 8'h02,
        OP_OR     = 8'h03,
        OP_XOR    = 8'h04,
        OP_PASS_A = 8'h05,
        OP_PASS_B = 8'h06
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_A    = 3'd1,
        ST_RX_B    = 3'd2,
        ST_EXEC    = 3'd3,
        ST_TX_LOAD = 3'd4,
        ST_TX_WAIT = 3'd5
    } state_e;

    localparam int         FLAG_CARRY = 0;
    localparam int         FLAG_ZERO  = 1;
    localparam logic [7:0] OPCODE_MAX = 8'h06;

    function automatic logic [7:0] pack_flags(input logic zero, input logic carry);
        logic [7:0] f;
        f             = 8'h00;
        f[FLAG_ZERO]  = zero;
        f[FLAG_CARRY] = carry;
        return f;
    endfunction

endpackage

// File: rtl/uart_alu_seq_alu_core.sv
// Combinational ALU: seven unsigned operations modulo 2^DATA_W with carry/borrow and zero.
module alu_core
    import uart_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [7:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              op_ok
);

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] diff_s;

    // Operation select; the extra top bit of diff_s is the unsigned borrow
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b};
        diff_s = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        op_ok  = (op <= OPCODE_MAX);
        case (op)
            OP_ADD: begin
                result = sum_s[DATA_W-1:0];
                carry  = sum_s[DATA_W];
            end
            OP_SUB: begin
                result = diff_s[DATA_W-1:0];
                carry  = diff_s[DATA_W];
            end
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_PASS_A: result = a;
            OP_PASS_B: result = b;
            default:   result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/uart_alu_seq.sv
// Frame assembler, ALU sequencer and response streamer between a UART receiver and transmitter.
module uart_alu_seq
    import uart_alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_busy,
    output logic              tx_wr_en,
    output logic [7:0]        tx_data,
    input  logic [1:0]        disp_sel,
    output logic [DATA_W-1:0] disp_data,
    output logic              result_valid,
    output logic              busy,
    output logic              err_opcode,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int NBYTES = DATA_W / 8;
    localparam int IDX_W  = $clog2(NBYTES + 2);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_BYTE = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] TX_LAST   = IDX_W'(NBYTES);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

    state_e             state_r;
    logic [7:0]         opcode_r;
    logic [DATA_W-1:0]  a_r;
    logic [DATA_W-1:0]  b_r;
    logic [DATA_W-1:0]  result_r;
    logic [7:0]         flags_r;
    logic [IDX_W-1:0]   byte_idx_r;
    logic [IDX_W-1:0]   tx_idx_r;
    logic [TO_W-1:0]    to_cnt_r;
    logic               guard_r;

    logic [DATA_W-1:0]  alu_result_s;
    logic               alu_carry_s;
    logic               alu_zero_s;
    logic               alu_ok_s;
    logic [IDX_W-1:0]   tx_next_idx_s;
    logic [7:0]         tx_next_byte_s;

    alu_core #(.DATA_W(DATA_W)) u_alu (
        .op     (opcode_r),
        .a      (a_r),
        .b      (b_r),
        .result (alu_result_s),
        .carry  (alu_carry_s),
        .zero   (alu_zero_s),
        .op_ok  (alu_ok_s)
    );

    // Next response byte: result bytes LSB first, flags byte last
    always_comb begin
        tx_next_idx_s = tx_idx_r + 1'b1;
        if (tx_next_idx_s == TX_LAST) begin
            tx_next_byte_s = flags_r;
        end else begin
            tx_next_byte_s = result_r[8*int'(tx_next_idx_s) +: 8];
        end
    end

    // Display word selection
    always_comb begin
        case (disp_sel)
            2'b00:   disp_data = result_r;
            2'b01:   disp_data = a_r;
            2'b10:   disp_data = b_r;
            2'b11:   disp_data = {{(DATA_W-8){1'b0}}, flags_r};
            default: disp_data = result_r;
        endcase
    end

    // Sequencer FSM with its datapath registers and registered pulse outputs
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            opcode_r     <= 8'h00;
            a_r          <= '0;
            b_r          <= '0;
            result_r     <= '0;
            flags_r      <= 8'h00;
            byte_idx_r   <= '0;
            tx_idx_r     <= '0;
            to_cnt_r     <= '0;
            guard_r      <= 1'b0;
            tx_wr_en     <= 1'b0;
            tx_data      <= 8'h00;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            err_opcode   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            tx_wr_en     <= 1'b0;
            result_valid <= 1'b0;
            err_opcode   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rx_valid) begin
                        opcode_r   <= rx_data;
                        byte_idx_r <= '0;
                        to_cnt_r   <= '0;
                        busy       <= 1'b1;
                        state_r    <= ST_RX_A;
                    end
                end
                ST_RX_A, ST_RX_B: begin
                    // An arriving byte takes priority over a timeout expiring in the same cycle
                    if (rx_valid) begin
                        to_cnt_r <= '0;
                        if (state_r == ST_RX_A) begin
                            a_r[8*int'(byte_idx_r) +: 8] <= rx_data;
                        end else begin
                            b_r[8*int'(byte_idx_r) +: 8] <= rx_data;
                        end
                        if (byte_idx_r == LAST_BYTE) begin
                            byte_idx_r <= '0;
                            state_r    <= (state_r == ST_RX_A) ? ST_RX_B : ST_EXEC;
                        end else begin
                            byte_idx_r <= byte_idx_r + 1'b1;
                        end
                    end else if (to_cnt_r == TO_LAST) begin
                        err_timeout <= 1'b1;
                        to_cnt_r    <= '0;
                        busy        <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (alu_ok_s) begin
                        result_r     <= alu_result_s;
                        flags_r      <= pack_flags(alu_zero_s, alu_carry_s);
                        result_valid <= 1'b1;
                        tx_idx_r     <= '0;
                        tx_data      <= alu_result_s[7:0];
                        tx_wr_en     <= ~tx_busy;
                        state_r      <= ST_TX_LOAD;
                    end else begin
                        err_opcode <= 1'b1;
                        busy       <= 1'b0;
                        state_r    <= ST_IDLE;
                    end
                end
                ST_TX_LOAD: begin
                    // The load pulse is issued only after tx_busy was seen low
                    if (tx_wr_en) begin
                        guard_r <= 1'b1;
                        state_r <= ST_TX_WAIT;
                    end else begin
                        tx_wr_en <= ~tx_busy;
                    end
                end
                ST_TX_WAIT: begin
                    if (guard_r) begin
                        guard_r <= 1'b0;
                    end else if (!tx_busy) begin
                        if (tx_idx_r == TX_LAST) begin
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            tx_idx_r <= tx_next_idx_s;
                            tx_data  <= tx_next_byte_s;
                            tx_wr_en <= 1'b1;
                            state_r  <= ST_TX_LOAD;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
            if (rx_valid && (state_r == ST_EXEC || state_r == ST_TX_LOAD || state_r == ST_TX_WAIT)) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_seq.sv
// Directed self-checking bench for uart_alu_seq (DATA_W=32, TIMEOUT_CYC=100).
module tb_uart_alu_seq;

    logic        clk_50m;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_busy;
    logic        tx_wr_en;
    logic [7:0]  tx_data;
    logic [1:0]  disp_sel;
    logic [31:0] disp_data;
    logic        result_valid;
    logic        busy;
    logic        err_opcode;
    logic        err_timeout;
    logic        err_overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    // monitor / transmitter model state
    logic [7:0] tx_q[$];
    int tx_cnt  = 0;
    int rv_cnt  = 0;
    int to_cnt  = 0;
    int oc_cnt  = 0;
    int ov_cnt  = 0;
    int bp_viol = 0;
    int bp_cycles = 0;
    int bcnt = 0;

    uart_alu_seq #(.DATA_W(32), .TIMEOUT_CYC(100)) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .tx_busy      (tx_busy),
        .tx_wr_en     (tx_wr_en),
        .tx_data      (tx_data),
        .disp_sel     (disp_sel),
        .disp_data    (disp_data),
        .result_valid (result_valid),
        .busy         (busy),
        .err_opcode   (err_opcode),
        .err_timeout  (err_timeout),
        .err_overrun  (err_overrun)
    );

    initial begin
        clk_50m = 1'b0;
        forever #10 clk_50m = ~clk_50m;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Pulse recorder plus a transmitter that stays busy bp_cycles after each load
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk_50m);
            if (tx_wr_en === 1'b1) begin
                tx_q.push_back(tx_data);
                tx_cnt++;
                if (tx_busy !== 1'b0) bp_viol++;
            end
            if (result_valid === 1'b1) rv_cnt++;
            if (err_timeout === 1'b1) to_cnt++;
            if (err_opcode === 1'b1) oc_cnt++;
            if (err_overrun === 1'b1) ov_cnt++;
            if (tx_wr_en === 1'b1 && bp_cycles > 0) begin
                tx_busy = 1'b1;
                bcnt = bp_cycles;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk_50m);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        send_byte(op);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[8*i +: 8]);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    task automatic chk_frame(input string tag, input int base, input logic [31:0] res, input logic [7:0] flg);
        logic [7:0] got;
        chk({tag, "_count"}, tx_cnt - base, 5);
        for (int i = 0; i < 5; i++) begin
            got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), got, (i < 4) ? res[8*i +: 8] : flg);
        end
    endtask

    task automatic chk_disp(input string tag, input logic [1:0] sel, input logic [31:0] exp);
        disp_sel = sel;
        #1;
        chk(tag, disp_data, exp);
    endtask

    int base_tx;
    int base_rv;

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        disp_sel = 2'b00;
        tick(3);

        // reset state
        chk("rst_tx_wr_en", tx_wr_en, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_errs", {err_opcode, err_timeout, err_overrun}, 3'b000);
        chk_disp("rst_disp_res", 2'b00, 32'h0);
        chk_disp("rst_disp_flags", 2'b11, 32'h0);
        rst = 1'b0;
        tick();

        // ADD with carry out, with exact first-byte latency
        base_tx = tx_cnt; base_rv = rv_cnt;
        send_frame(8'h00, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("add_t1_busy", busy, 1'b1);
        chk("add_t1_wr", tx_wr_en, 1'b0);
        chk("add_t1_rv", result_valid, 1'b0);
        tick();
        chk("add_t2_rv", result_valid, 1'b1);
        chk("add_t2_wr", tx_wr_en, 1'b1);
        chk("add_t2_data", tx_data, 8'h01);
        wait_idle("add_idle", 200);
        chk_frame("add", base_tx, 32'h0000_0001, 8'h01);
        chk("add_rv_once", rv_cnt - base_rv, 1);
        chk_disp("add_disp_res", 2'b00, 32'h0000_0001);
        chk_disp("add_disp_a", 2'b01, 32'hFFFF_FFFF);
        chk_disp("add_disp_b", 2'b10, 32'h0000_0002);
        chk_disp("add_disp_flags", 2'b11, 32'h0000_0001);

        // SUB with borrow
        base_tx = tx_cnt;
        send_frame(8'h01, 32'h0000_0005, 32'h0000_0007);
        wait_idle("subb_idle", 200);
        chk_frame("subb", base_tx, 32'hFFFF_FFFE, 8'h01);

        // SUB of equal operands -> zero
        base_tx = tx_cnt;
        send_frame(8'h01, 32'h7856_3412, 32'h7856_3412);
        wait_idle("subz_idle", 200);
        chk_frame("subz", base_tx, 32'h0000_0000, 8'h02);
        chk_disp("subz_disp_flags", 2'b11, 32'h0000_0002);

        // invalid opcode: operands consumed, no response, result/flags kept
        base_tx = tx_cnt; base_rv = rv_cnt;
        send_frame(8'h09, 32'hAAAA_AAAA, 32'h5555_5555);
        chk("inv_t1_err", err_opcode, 1'b0);
        tick();
        chk("inv_t2_err", err_opcode, 1'b1);
        chk("inv_t2_busy", busy, 1'b0);
        tick(5);
        chk("inv_no_tx", tx_cnt - base_tx, 0);
        chk("inv_no_rv", rv_cnt - base_rv, 0);
        chk_disp("inv_disp_flags", 2'b11, 32'h0000_0002);
        chk_disp("inv_disp_a", 2'b01, 32'hAAAA_AAAA);

        // a following ADD frame stays aligned
        base_tx = tx_cnt;
        send_frame(8'h00, 32'h0000_0010, 32'h0000_0020);
        wait_idle("postinv_idle", 200);
        chk_frame("postinv", base_tx, 32'h0000_0030, 8'h00);

        // inter-byte timeout, with a byte landing exactly on the expiry cycle
        send_byte(8'h00);
        send_byte(8'h11);
        tick(99);
        send_byte(8'h22);
        chk("to_bytewins_err", err_timeout, 1'b0);
        chk("to_bytewins_busy", busy, 1'b1);
        tick(99);
        chk("to_c100_err", err_timeout, 1'b0);
        chk("to_c100_busy", busy, 1'b1);
        tick();
        chk("to_c101_err", err_timeout, 1'b1);
        chk("to_c101_busy", busy, 1'b0);
        tick();
        chk("to_c102_err", err_timeout, 1'b0);
        tick(47);
        chk("to_count", to_cnt, 1);
        chk_disp("to_disp_a", 2'b01, 32'h0000_2211);

        // next byte is an opcode (PASS_A)
        base_tx = tx_cnt;
        send_frame(8'h05, 32'h1234_5678, 32'h0000_0000);
        wait_idle("pass_idle", 200);
        chk_frame("pass", base_tx, 32'h1234_5678, 8'h00);

        // back-pressure plus overrun during transmission (XOR)
        bp_cycles = 50;
        base_tx = tx_cnt;
        send_frame(8'h04, 32'hF0F0_F0F0, 32'hFF00_FF00);
        tick(21);
        send_byte(8'h55);
        chk("ovr_pulse", err_overrun, 1'b1);
        wait_idle("bp_idle", 1000);
        chk_frame("bp", base_tx, 32'h0FF0_0FF0, 8'h00);
        chk("bp_after_busy_low", bp_viol, 0);
        chk("ovr_count", ov_cnt, 1);

        // reset after the 2nd response byte
        bp_cycles = 10;
        base_tx = tx_cnt;
        send_frame(8'h00, 32'h0000_0001, 32'h0000_0001);
        for (int n = 0; n < 500 && (tx_cnt - base_tx) < 2; n++) tick();
        chk("rstm_two_bytes", tx_cnt - base_tx, 2);
        rst = 1'b1;
        tick();
        chk("rstm_wr", tx_wr_en, 1'b0);
        chk("rstm_data", tx_data, 8'h00);
        chk("rstm_busy", busy, 1'b0);
        chk("rstm_rv_errs", {result_valid, err_opcode, err_timeout, err_overrun}, 4'b0000);
        chk_disp("rstm_disp_res", 2'b00, 32'h0);
        chk_disp("rstm_disp_a", 2'b01, 32'h0);
        rst = 1'b0;
        tick(100);
        chk("rstm_no_more_tx", tx_cnt - base_tx, 2);
        chk("oc_total", oc_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
